// File: rtl/stream_congestion_emulator.sv
// stream_congestion_emulator: one-deep stream register slice with congestion-gated upstream ready
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            gating enable (0 = gate always open)
//   data_i/valid_i      upstream payload and valid; ready_o upstream ready (gated)
//   data_o/valid_o      downstream payload and valid; ready_i downstream ready
//   stall_cnt_o         saturating count of cycles with valid_i && !ready_o
//   beat_cnt_o          saturating count of output beats (valid_o && ready_i)
// Optional feature: define STREAM_CONGESTION_EMULATOR_STATS_EN to build the two
// statistics counters; otherwise both outputs are tied to zero.
module stream_congestion_emulator #(
  parameter int          DATA_WIDTH       = 32,
  parameter int          CONGESTION_LEVEL = 50,
  parameter int          MODE             = 0,
  parameter int          PERIOD           = 16,
  parameter int          MAX_STALL        = 0,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           beat_cnt_o
);
  // An all-zero seed would lock the LFSR, so it is replaced by the default
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  // 9 bits so that level 100 (256) can never be reached by an 8-bit sample
  localparam logic [8:0]  THRESH    = 9'(CONGESTION_LEVEL * 256 / 100);
  localparam logic [31:0] CLOSED    = 32'(PERIOD * CONGESTION_LEVEL / 100);
  localparam logic [31:0] LAST      = 32'(PERIOD - 1);
  localparam logic [31:0] STALL_MAX = 32'(MAX_STALL);
  logic [DATA_WIDTH-1:0] data_q;
  logic                  full_q;
  logic [15:0]           lfsr_q;
  logic [31:0]           phase_q;
  logic [31:0]           run_q;
  logic                  gate;
  logic                  open;
  logic                  load;
  always_comb begin
    gate = (MODE == 1) ? (phase_q >= CLOSED) : ({1'b0, lfsr_q[7:0]} >= THRESH);
    // watchdog forces one open cycle after MAX_STALL consecutive closed ones
    open = !enable_i || gate || ((MAX_STALL > 0) && (run_q >= STALL_MAX));
  end
  assign ready_o = !rst_i && open && (!full_q || ready_i);
  assign load    = valid_i && ready_o;
  assign valid_o = full_q;
  assign data_o  = data_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      full_q  <= 1'b0;
      lfsr_q  <= SEED;
      phase_q <= '0;
      run_q   <= '0;
    end else begin
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      phase_q <= (phase_q >= LAST) ? '0 : phase_q + 32'd1;
      run_q   <= open ? '0 : run_q + 32'd1;
      // a load wins over a drain; with neither, a full stage holds until ready_i
      full_q  <= load || (full_q && !ready_i);
      if (load) data_q <= data_i;
    end
  end
`ifdef STREAM_CONGESTION_EMULATOR_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] beat_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      beat_q  <= '0;
    end else begin
      if (valid_i && !ready_o && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (full_q && ready_i && beat_q != '1) beat_q <= beat_q + 32'd1;
    end
  end
  assign stall_cnt_o = stall_q;
  assign beat_cnt_o  = beat_q;
`else
  assign stall_cnt_o = '0;
  assign beat_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_stream_congestion_emulator.sv
// tb_stream_congestion_emulator: directed self-checking bench for stream_congestion_emulator
module tb_stream_congestion_emulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        en   [4];
  logic        v    [4];
  logic        r    [4];
  logic [31:0] d    [4];
  wire         ro   [4];
  wire         vo   [4];
  wire  [31:0] dout [4];
  wire  [31:0] sc   [4];
  wire  [31:0] bc   [4];
  int n_chk = 0;
  int n_fail = 0;
`ifdef STREAM_CONGESTION_EMULATOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  // u0: always open; u1: periodic 10/30%; u2: never open, watchdog 8; u3: default random 50%
  stream_congestion_emulator #(.CONGESTION_LEVEL(0)) u0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .data_i(d[0]), .valid_i(v[0]), .ready_o(ro[0]),
    .data_o(dout[0]), .valid_o(vo[0]), .ready_i(r[0]), .stall_cnt_o(sc[0]), .beat_cnt_o(bc[0]));
  stream_congestion_emulator #(.MODE(1), .PERIOD(10), .CONGESTION_LEVEL(30)) u1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .data_i(d[1]), .valid_i(v[1]), .ready_o(ro[1]),
    .data_o(dout[1]), .valid_o(vo[1]), .ready_i(r[1]), .stall_cnt_o(sc[1]), .beat_cnt_o(bc[1]));
  stream_congestion_emulator #(.CONGESTION_LEVEL(100), .MAX_STALL(8)) u2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[2]), .data_i(d[2]), .valid_i(v[2]), .ready_o(ro[2]),
    .data_o(dout[2]), .valid_o(vo[2]), .ready_i(r[2]), .stall_cnt_o(sc[2]), .beat_cnt_o(bc[2]));
  stream_congestion_emulator u3 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[3]), .data_i(d[3]), .valid_i(v[3]), .ready_o(ro[3]),
    .data_o(dout[3]), .valid_o(vo[3]), .ready_i(r[3]), .stall_cnt_o(sc[3]), .beat_cnt_o(bc[3]));
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_data;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ex(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b1; v[i] = 1'b0; r[i] = 1'b1; d[i] = '0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_ready[%0d]", i), 32'(ro[i]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 32'(vo[i]), 32'd0);
      chk($sformatf("rst_data[%0d]", i), dout[i], 32'd0);
      chk($sformatf("rst_stall[%0d]", i), sc[i], 32'd0);
      chk($sformatf("rst_beat[%0d]", i), bc[i], 32'd0);
    end
  endtask
  // u3 with valid_i=0, ready_i=1: ready_o is the raw random gate, modelled from the seed
  task automatic gate_run(input string nm);
    logic [15:0] l;
    l = 16'hACE1;
    v[3] = 1'b0; r[3] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk($sformatf("%s[%0d]", nm, i), 32'(ro[3]), 32'(l[7:0] >= 8'd128));
      @(posedge clk); #1;
      l = lfsr_next(l);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int acc;
    logic found;
    tbl[0] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1};
    tbl[1] = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1};
    tbl[2] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA3};
    tbl[3] = '{1'b0, 32'hFF, 1'b1, 1'b1, 1'b0, 32'hA3};
    tbl[4] = '{1'b0, 32'hBB, 1'b0, 1'b1, 1'b0, 32'hA3};
    tbl[5] = '{1'b1, 32'hC5, 1'b0, 1'b1, 1'b1, 32'hC5};
    tbl[6] = '{1'b1, 32'hC6, 1'b0, 1'b0, 1'b1, 32'hC5};
    tbl[7] = '{1'b0, 32'hC7, 1'b0, 1'b0, 1'b1, 32'hC5};
    tbl[8] = '{1'b0, 32'hC8, 1'b1, 1'b1, 1'b0, 32'hC5};
    tbl[9] = '{1'b1, 32'hD9, 1'b1, 1'b1, 1'b1, 32'hD9};
    // always open: 100 beats in 101 cycles, in order
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      v[0] = 1'b1; d[0] = 32'(k); #1;
      chk("a_ready", 32'(ro[0]), 32'd1);
      @(posedge clk); #1;
      chk("a_valid", 32'(vo[0]), 32'd1);
      chk("a_data", dout[0], 32'(k));
    end
    v[0] = 1'b0;
    @(posedge clk); #1;
    chk("a_drained", 32'(vo[0]), 32'd0);
    chk("a_beats", bc[0], ex(100));
    chk("a_stalls", sc[0], 32'd0);
    // periodic: closed at phases 0..2 of each 10-cycle window
    do_reset();
    acc = 0;
    v[1] = 1'b1; r[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d[1] = 32'(i); #1;
      chk($sformatf("b_ready[%0d]", i), 32'(ro[1]), 32'((i % 10) >= 3));
      if (ro[1]) acc++;
      @(posedge clk); #1;
    end
    v[1] = 1'b0;
    @(posedge clk); #1;
    chk("b_accepted", 32'(acc), 32'd70);
    chk("b_stalls", sc[1], ex(30));
    chk("b_beats", bc[1], ex(70));
    // gating disabled on a never-open instance: plain register slice
    do_reset();
    en[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v[2] = tbl[i].v; d[2] = tbl[i].d; r[2] = tbl[i].r; #1;
      chk($sformatf("t_ready[%0d]", i), 32'(ro[2]), 32'(tbl[i].e_ready));
      @(posedge clk); #1;
      chk($sformatf("t_valid[%0d]", i), 32'(vo[2]), 32'(tbl[i].e_valid));
      chk($sformatf("t_data[%0d]", i), dout[2], tbl[i].e_data);
    end
    chk("t_stalls", sc[2], ex(2));
    chk("t_beats", bc[2], ex(3));
    // never open, watchdog forces one open cycle out of every 9
    do_reset();
    acc = 0;
    v[2] = 1'b1; r[2] = 1'b1;
    for (int i = 0; i < 90; i++) begin
      d[2] = 32'(i); #1;
      chk($sformatf("c_ready[%0d]", i), 32'(ro[2]), 32'((i % 9) == 8));
      if (ro[2]) acc++;
      @(posedge clk); #1;
    end
    chk("c_accepted", 32'(acc), 32'd10);
    chk("c_stalls", sc[2], ex(80));
    // random gate, backpressure hold, mid-operation reset, gate replay
    do_reset();
    gate_run("d_gate1");
    v[3] = 1'b1; d[3] = 32'h5A5A_5A5A; r[3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      #1;
      found = ro[3];
      @(posedge clk); #1;
    end
    chk("d_loaded", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) begin
      d[3] = 32'(i); #1;
      chk("d_hold_ready", 32'(ro[3]), 32'd0);
      @(posedge clk); #1;
      chk("d_hold_valid", 32'(vo[3]), 32'd1);
      chk("d_hold_data", dout[3], 32'h5A5A_5A5A);
    end
    r[3] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("d_rst_ready", 32'(ro[3]), 32'd0);
    chk("d_rst_valid", 32'(vo[3]), 32'd0);
    chk("d_rst_data", dout[3], 32'd0);
    chk("d_rst_stall", sc[3], 32'd0);
    chk("d_rst_beat", bc[3], 32'd0);
    rst = 1'b0;
    gate_run("d_gate2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
